// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port 0 (core LSU) has fixed
// priority, port 1 is guaranteed a grant after STARVE_LIMIT refused cycles.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int MASK_SIZE   = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,

    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    input  logic [MASK_SIZE-1:0]  m0_mask_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic [MASK_SIZE-1:0]  m1_mask_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [MASK_SIZE-1:0]  mem_mask_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  core_stall_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_port_q, rsp_port_d;
    logic       rsp_we_q, rsp_we_d;
    logic       starved;

    // Grants and every memory-side output are gated by reset so nothing leaks while held.
    always_comb begin
        starved      = (starve_cnt_q == LIMIT);
        m1_gnt_o     = arst_n_i & m1_req_i & (starved | ~m0_req_i);
        m0_gnt_o     = arst_n_i & m0_req_i & ~m1_gnt_o;
        core_stall_o = arst_n_i & m0_req_i & ~m0_gnt_o;
    end

    always_comb begin
        mem_en_o    = m0_gnt_o | m1_gnt_o;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_mask_o  = '0;
        if (m0_gnt_o) begin
            mem_we_o    = m0_we_i;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
            mem_mask_o  = m0_mask_i;
        end else if (m1_gnt_o) begin
            mem_we_o    = m1_we_i;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
            mem_mask_o  = m1_mask_i;
        end
    end

    always_comb begin
        if (!m1_req_i || m1_gnt_o) begin
            starve_cnt_d = '0;
        end else if (starved) begin
            starve_cnt_d = LIMIT;
        end else begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        rsp_valid_d = mem_en_o;
        rsp_port_d  = m1_gnt_o;
        rsp_we_d    = mem_we_o;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            starve_cnt_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_port_q   <= 1'b0;
            rsp_we_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_port_q   <= rsp_port_d;
            rsp_we_q     <= rsp_we_d;
        end
    end

    // Write responses carry no data, so their rdata is forced to zero.
    always_comb begin
        m0_rvalid_o = arst_n_i & rsp_valid_q & ~rsp_port_q;
        m1_rvalid_o = arst_n_i & rsp_valid_q & rsp_port_q;
        m0_rdata_o  = (m0_rvalid_o && !rsp_we_q) ? mem_rdata_i : '0;
        m1_rdata_o  = (m1_rvalid_o && !rsp_we_q) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: a cycle-level reference model predicts
// grants and memory-side outputs and queues expected responses per port.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m0_mask = 0, m1_mask = 0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we, core_stall;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata = 0;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_mask_i(m0_mask), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_mask_i(m1_mask), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_mask_o(mem_mask), .mem_rdata_i(mem_rdata), .core_stall_o(core_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic any_out();
        return m0_gnt | m1_gnt | m0_rvalid | m1_rvalid | (|m0_rdata) | (|m1_rdata) | mem_en |
               mem_we | (|mem_addr) | (|mem_wdata) | (|mem_mask) | core_stall;
    endfunction

    // Memory device: one-cycle read latency; junk on the data bus after a write.
    logic [31:0] devmem [16];
    logic [31:0] refmem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) devmem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                mem_rdata <= $urandom;
            end else begin
                mem_rdata <= devmem[mem_addr[5:2]];
            end
        end
    end

    // Reference model and monitor
    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;
    rsp_t q0[$];
    rsp_t q1[$];
    int   cyc = 0;
    int   waited = 0;
    rsp_t e;
    logic x0, x1, xwe, xstall;
    logic [31:0] xaddr, xwdata;
    logic [3:0]  xmask;
    logic g0_s = 0, g1_s = 0;

    always @(negedge clk) begin
        cyc++;
        g0_s = m0_gnt;
        g1_s = m1_gnt;
        if (!arst_n) begin
            chk("reset_outputs", any_out(), 0);
            chk("reset_starve", dut.starve_cnt_q, 0);
            q0.delete();
            q1.delete();
            waited = 0;
        end else begin
            if (q0.size() > 0 && q0[0].due <= cyc) begin
                e = q0.pop_front();
                chk("m0_rsp", {m0_rvalid, m0_rdata}, {1'b1, e.data});
            end else begin
                chk("m0_norsp", {m0_rvalid, m0_rdata}, 33'b0);
            end
            if (q1.size() > 0 && q1[0].due <= cyc) begin
                e = q1.pop_front();
                chk("m1_rsp", {m1_rvalid, m1_rdata}, {1'b1, e.data});
            end else begin
                chk("m1_norsp", {m1_rvalid, m1_rdata}, 33'b0);
            end
            chk("starve_cnt", dut.starve_cnt_q, waited);

            x1 = m1_req && (waited >= LIMIT || !m0_req);
            x0 = m0_req && !x1;
            xstall = m0_req && !x0;
            xwe = 0; xaddr = 0; xwdata = 0; xmask = 0;
            if (x0) begin xwe = m0_we; xaddr = m0_addr; xwdata = m0_wdata; xmask = m0_mask; end
            if (x1) begin xwe = m1_we; xaddr = m1_addr; xwdata = m1_wdata; xmask = m1_mask; end
            chk("arb", {m0_gnt, m1_gnt, core_stall, mem_en, mem_we, mem_addr, mem_wdata, mem_mask},
                {x0, x1, xstall, x0 | x1, xwe, xaddr, xwdata, xmask});

            if (x0 || x1) begin
                e.due  = cyc + 1;
                e.data = xwe ? 32'h0 : refmem[xaddr[5:2]];
                if (x0) q0.push_back(e); else q1.push_back(e);
                if (xwe)
                    for (int b = 0; b < 4; b++)
                        if (xmask[b]) refmem[xaddr[5:2]][8*b +: 8] = xwdata[8*b +: 8];
            end
            waited = (m1_req && !x1) ? ((waited >= LIMIT) ? LIMIT : waited + 1) : 0;
        end
    end

    task automatic drv0(input logic r, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
        m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; m0_mask = m;
    endtask

    task automatic drv1(input logic r, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
        m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; m1_mask = m;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] pat;

    initial begin
        for (int i = 0; i < 16; i++) begin
            devmem[i] = $urandom;
            refmem[i] = devmem[i];
        end
        // Requests held during reset must not produce grants.
        drv0(1, 0, 32'h10, 0, 0);
        drv1(1, 0, 32'h20, 0, 0);
        nxt(); nxt(); nxt();
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        nxt();
        arst_n = 1;
        nxt();

        // Port 0 alone: write then read back
        drv0(1, 1, 32'h10, 32'hDEADBEEF, 4'hF); nxt();
        drv0(1, 0, 32'h10, 0, 0); nxt();
        drv0(0, 0, 0, 0, 0); nxt(); nxt();

        // Port 1 alone: byte write on lane 1 then read
        drv1(1, 1, 32'h20, 32'h0000AB00, 4'h2); nxt();
        drv1(1, 0, 32'h20, 0, 0); nxt();
        drv1(0, 0, 0, 0, 0); nxt(); nxt();

        // Continuous contention for 12 cycles
        drv0(1, 0, 32'h10, 0, 0);
        drv1(1, 0, 32'h20, 0, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat[i] = m1_gnt;
            @(posedge clk);
            #1;
        end
        chk("contention_m1_gnt_pattern", pat, 12'h210);
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        nxt(); nxt();

        // Interleaved reads from both ports
        drv0(1, 0, 32'h10, 0, 0); nxt();
        drv0(0, 0, 0, 0, 0);
        drv1(1, 0, 32'h20, 0, 0); nxt();
        drv1(0, 0, 0, 0, 0); nxt(); nxt();

        // Reset one cycle after a port 0 read grant, with port 1 requesting
        drv0(1, 0, 32'h10, 0, 0); nxt();
        drv0(0, 0, 0, 0, 0);
        drv1(1, 0, 32'h28, 0, 0);
        #1;
        arst_n = 0;
        #1;
        chk("reset_immediate", any_out(), 0);
        nxt(); nxt();
        arst_n = 1;
        nxt();
        drv1(0, 0, 0, 0, 0);
        nxt(); nxt();

        // m1 refused twice behind m0, then withdrawn
        drv0(1, 0, 32'h14, 0, 0);
        drv1(1, 1, 32'h24, 32'h12345678, 4'hF);
        nxt(); nxt();
        drv1(0, 0, 0, 0, 0); nxt();
        drv0(0, 0, 0, 0, 0); nxt(); nxt();

        // Random traffic obeying the hold-until-grant rule
        for (int c = 0; c < 3000; c++) begin
            if (!m0_req || g0_s) begin
                if ($urandom_range(0, 99) < 60)
                    drv0(1, 1'($urandom), {26'b0, 4'($urandom), 2'b0}, $urandom, 4'($urandom));
                else
                    drv0(0, 0, 0, 0, 0);
            end
            if (!m1_req || g1_s) begin
                if ($urandom_range(0, 99) < 60)
                    drv1(1, 1'($urandom), {26'b0, 4'($urandom), 2'b0}, $urandom, 4'($urandom));
                else
                    drv1(0, 0, 0, 0, 0);
            end
            nxt();
        end
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        nxt(); nxt(); nxt();
        chk("pending_responses", q0.size() + q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
